// File: rtl/rotate_commit_if.sv
// Shared piece/orientation types and the request/board-read bundle for the
// rotation commit arbiter.
package rotate_commit_pkg;
    typedef enum logic [2:0] {CYAN, YELLOW, PURPLE, GREEN, RED, BLUE, ORANGE} block_color;
    typedef enum logic [1:0] {NORMAL, ROT_LEFT, ROT2, ROT_RIGHT} orientation;
endpackage

interface rotate_commit_if;
    import rotate_commit_pkg::*;

    logic        rot_req;
    logic        rotate_left;
    block_color  block;
    orientation  cur_orientation;
    logic [19:0] x_block;
    logic [19:0] y_block;
    logic [19:0] rot_xblock;
    logic [19:0] rot_yblock;
    logic        rd_en;
    logic [4:0]  rd_x;
    logic [4:0]  rd_y;
    logic        rd_data;
    logic        busy;
    logic        done;
    logic        accepted;
    logic [19:0] new_xblock;
    logic [19:0] new_yblock;
    orientation  new_orientation;

    // Controller plus board-memory side
    modport master (
        output rot_req, rotate_left, block, cur_orientation,
               x_block, y_block, rot_xblock, rot_yblock, rd_data,
        input  rd_en, rd_x, rd_y, busy, done, accepted,
               new_xblock, new_yblock, new_orientation
    );

    modport slave (
        input  rot_req, rotate_left, block, cur_orientation,
               x_block, y_block, rot_xblock, rot_yblock, rd_data,
        output rd_en, rd_x, rd_y, busy, done, accepted,
               new_xblock, new_yblock, new_orientation
    );
endinterface

// File: rtl/rotate_commit.sv
// Rotation arbiter: bounds-checks the proposed cells, probes the locked-cell
// board one cell at a time, then commits or rejects the rotation.
//
// state    | meaning
// S_IDLE   | waiting for rot_req; request fields latched on acceptance
// S_BOUNDS | all four proposed cells tested against the board limits
// S_READ   | board read strobe for proposed cell[idx]
// S_WAIT   | board data for cell[idx] returns; reject, advance or accept
// S_RESP   | done pulse, result and committed cells visible
module rotate_commit
    import rotate_commit_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input  logic          Clk,
    input  logic          Reset,
    rotate_commit_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_BOUNDS, S_READ, S_WAIT, S_RESP} state_t;

    localparam logic [5:0] X_LIM = 6'(BOARD_W);
    localparam logic [5:0] Y_LIM = 6'(BOARD_H);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        left_q;
    orientation  orient_q;
    logic [19:0] rot_x_q, rot_y_q;

    logic        busy_q, done_q, accepted_q;
    logic [19:0] new_x_q, new_y_q;
    orientation  new_o_q;

    logic        latch_en;
    logic        result_d;
    logic [19:0] commit_x, commit_y;
    orientation  commit_o;

    logic [4:0]  px [4];
    logic [4:0]  py [4];
    logic        oob;

    function automatic orientation advance(orientation o, logic left);
        case (o)
            NORMAL:   return left ? ROT_LEFT  : ROT_RIGHT;
            ROT_LEFT: return left ? ROT2      : NORMAL;
            ROT2:     return left ? ROT_RIGHT : ROT_LEFT;
            default:  return left ? NORMAL    : ROT2;
        endcase
    endfunction

    // Coordinates are unsigned, so a wrapped value (0-1 = 31) fails here too
    always_comb begin
        oob = 1'b0;
        for (int i = 0; i < 4; i++) begin
            px[i] = rot_x_q[5*i +: 5];
            py[i] = rot_y_q[5*i +: 5];
            if (({1'b0, px[i]} >= X_LIM) || ({1'b0, py[i]} >= Y_LIM)) begin
                oob = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        latch_en = 1'b0;
        result_d = 1'b0;
        commit_x = rot_x_q;
        commit_y = rot_y_q;
        commit_o = advance(orient_q, left_q);
        case (state_q)
            S_IDLE: begin
                if (bus.rot_req) begin
                    latch_en = 1'b1;
                    idx_d    = 2'd0;
                    // The O piece is rotation-invariant: accept without touching the board
                    if (bus.block == YELLOW) begin
                        state_d  = S_RESP;
                        result_d = 1'b1;
                        commit_x = bus.x_block;
                        commit_y = bus.y_block;
                        commit_o = bus.cur_orientation;
                    end else begin
                        state_d = S_BOUNDS;
                    end
                end
            end
            S_BOUNDS: state_d = oob ? S_RESP : S_READ;
            S_READ:   state_d = S_WAIT;
            S_WAIT: begin
                if (bus.rd_data) begin
                    state_d = S_RESP;
                end else if (idx_q == 2'd3) begin
                    state_d  = S_RESP;
                    result_d = 1'b1;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_READ;
                end
            end
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            left_q     <= 1'b0;
            orient_q   <= NORMAL;
            rot_x_q    <= '0;
            rot_y_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            accepted_q <= 1'b0;
            new_x_q    <= '0;
            new_y_q    <= '0;
            new_o_q    <= NORMAL;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch_en) begin
                left_q   <= bus.rotate_left;
                orient_q <= bus.cur_orientation;
                rot_x_q  <= bus.rot_xblock;
                rot_y_q  <= bus.rot_yblock;
            end
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_d == S_RESP);
            // Result is registered on entry to S_RESP so it appears alongside done
            if (state_d == S_RESP) begin
                accepted_q <= result_d;
                if (result_d) begin
                    new_x_q <= commit_x;
                    new_y_q <= commit_y;
                    new_o_q <= commit_o;
                end
            end
        end
    end

    assign bus.rd_en           = (state_q == S_READ);
    assign bus.rd_x            = (state_q == S_READ) ? px[idx_q] : 5'd0;
    assign bus.rd_y            = (state_q == S_READ) ? py[idx_q] : 5'd0;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.accepted        = accepted_q;
    assign bus.new_xblock      = new_x_q;
    assign bus.new_yblock      = new_y_q;
    assign bus.new_orientation = new_o_q;

endmodule

// File: tb/tb_rotate_commit.sv
// Bench for rotate_commit: schedule-level reference model with a per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_rotate_commit;
    import rotate_commit_pkg::*;

    localparam int BW = 10;
    localparam int BH = 20;

    logic clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    rotate_commit_if bus();

    rotate_commit #(.BOARD_W(BW), .BOARD_H(BH)) dut (
        .Clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    bit board [32][32];

    // Board memory: one-cycle read latency
    always @(posedge clk) bus.rd_data <= bus.rd_en ? board[bus.rd_x][bus.rd_y] : 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [4:0] rx;
        logic [4:0] ry;
    } cyc_t;

    cyc_t        sched[$];
    cyc_t        cur  = '0;
    logic        m_acc = 1'b0;
    logic [19:0] m_nx  = '0;
    logic [19:0] m_ny  = '0;
    orientation  m_no  = NORMAL;
    logic        p_acc = 1'b0;
    logic [19:0] p_nx  = '0;
    logic [19:0] p_ny  = '0;
    orientation  p_no  = NORMAL;

    function automatic cyc_t mk(logic b, logic d, logic r, logic [4:0] x, logic [4:0] y);
        cyc_t c;
        c.busy = b; c.done = d; c.rd_en = r; c.rx = x; c.ry = y;
        return c;
    endfunction

    function automatic orientation rule_next(orientation o, logic left);
        orientation ring [4];
        int pos;
        ring[0] = NORMAL; ring[1] = ROT_LEFT; ring[2] = ROT2; ring[3] = ROT_RIGHT;
        pos = 0;
        for (int i = 0; i < 4; i++) if (ring[i] == o) pos = i;
        return left ? ring[(pos + 1) % 4] : ring[(pos + 3) % 4];
    endfunction

    // Expected per-cycle timeline of one request, cycle 1 .. done cycle
    task automatic plan_request();
        logic [4:0] x [4];
        logic [4:0] y [4];
        bit oob;
        int hit;
        oob = 0;
        hit = -1;
        for (int i = 0; i < 4; i++) begin
            x[i] = bus.rot_xblock[5*i +: 5];
            y[i] = bus.rot_yblock[5*i +: 5];
            if (int'(x[i]) >= BW || int'(y[i]) >= BH) oob = 1;
        end
        if (bus.block == YELLOW) begin
            sched.push_back(mk(1, 1, 0, 0, 0));
            p_acc = 1; p_nx = bus.x_block; p_ny = bus.y_block; p_no = bus.cur_orientation;
            return;
        end
        sched.push_back(mk(1, 0, 0, 0, 0));
        if (oob) begin
            sched.push_back(mk(1, 1, 0, 0, 0));
            p_acc = 0;
            return;
        end
        for (int j = 0; j < 4; j++) begin
            sched.push_back(mk(1, 0, 1, x[j], y[j]));
            sched.push_back(mk(1, 0, 0, 0, 0));
            if (board[x[j]][y[j]]) begin
                hit = j;
                break;
            end
        end
        sched.push_back(mk(1, 1, 0, 0, 0));
        p_acc = (hit < 0);
        p_nx  = bus.rot_xblock;
        p_ny  = bus.rot_yblock;
        p_no  = rule_next(bus.cur_orientation, bus.rotate_left);
    endtask

    always @(posedge clk) begin
        if (Reset) begin
            sched.delete();
            cur = '0; m_acc = 0; m_nx = '0; m_ny = '0; m_no = NORMAL;
        end else begin
            if (sched.size() == 0 && !cur.busy && bus.rot_req) plan_request();
            if (sched.size() > 0) begin
                cur = sched.pop_front();
                if (cur.done) begin
                    m_acc = p_acc;
                    if (p_acc) begin
                        m_nx = p_nx; m_ny = p_ny; m_no = p_no;
                    end
                end
            end else begin
                cur = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",     bus.busy,     cur.busy);
            chk("done",     bus.done,     cur.done);
            chk("rd_en",    bus.rd_en,    cur.rd_en);
            if (cur.rd_en) begin
                chk("rd_x", bus.rd_x, cur.rx);
                chk("rd_y", bus.rd_y, cur.ry);
            end
            chk("accepted", bus.accepted,   m_acc);
            chk("new_x",    bus.new_xblock, m_nx);
            chk("new_y",    bus.new_yblock, m_ny);
            chk("new_ori",  bus.new_orientation, m_no);
        end
    end

    // ---------------- stimulus ----------------
    logic       snap_busy, snap_rden;
    orientation snap_ori;

    task automatic scramble();
        bus.block           = block_color'(3'($urandom_range(0, 6)));
        bus.rotate_left     = 1'($urandom);
        bus.cur_orientation = orientation'(2'($urandom));
        bus.x_block         = 20'($urandom);
        bus.y_block         = 20'($urandom);
        bus.rot_xblock      = 20'($urandom);
        bus.rot_yblock      = 20'($urandom);
    endtask

    function automatic logic [19:0] rand_cells(int lim);
        logic [19:0] v;
        for (int i = 0; i < 4; i++)
            v[5*i +: 5] = ($urandom % 24 == 0) ? 5'($urandom) : 5'($urandom % lim);
        return v;
    endfunction

    task automatic run_req(input block_color blk, input logic left, input orientation ori,
                           input logic [19:0] cx, input logic [19:0] cy,
                           input logic [19:0] rx, input logic [19:0] ry,
                           input int pulse_c, input int rst_c,
                           output int done_c, output int ndone, output int mask,
                           output int last_x, output int last_y);
        @(negedge clk);
        bus.block = blk; bus.rotate_left = left; bus.cur_orientation = ori;
        bus.x_block = cx; bus.y_block = cy; bus.rot_xblock = rx; bus.rot_yblock = ry;
        bus.rot_req = 1'b1;
        done_c = -1; ndone = 0; mask = 0; last_x = -1; last_y = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (bus.rd_en) begin
                mask |= (1 << c);
                last_x = int'(bus.rd_x);
                last_y = int'(bus.rd_y);
            end
            if (c == rst_c + 1) begin
                snap_busy = bus.busy; snap_rden = bus.rd_en; snap_ori = bus.new_orientation;
            end
            scramble();
            bus.rot_req = (c == pulse_c);
            Reset       = (c == rst_c);
        end
    endtask

    initial begin
        int dc, nd, mk_, lx, ly;
        bit fin;
        bus.rot_req = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_acc",  bus.accepted, 0);
        chk("rst_rden", bus.rd_en, 0);
        chk("rst_rdx",  bus.rd_x, 0);
        chk("rst_newx", bus.new_xblock, 0);
        chk("rst_ori",  bus.new_orientation, NORMAL);
        cmp_en = 1'b1;
        Reset  = 1'b0;

        // Full accept, empty board
        run_req(CYAN, 1, NORMAL, {5'd3,5'd4,5'd5,5'd6}, {4{5'd2}},
                {4{5'd5}}, {5'd4,5'd3,5'd2,5'd1}, -1, -1, dc, nd, mk_, lx, ly);
        chk("t1_done_cyc", dc, 10);
        chk("t1_ndone", nd, 1);
        chk("t1_rd_mask", mk_, 32'h154);
        chk("t1_last_rd", {lx[15:0], ly[15:0]}, {16'd5, 16'd4});
        chk("t1_acc", bus.accepted, 1);
        chk("t1_ori", bus.new_orientation, ROT_LEFT);
        chk("t1_new_x", bus.new_xblock, {4{5'd5}});
        chk("t1_new_y", bus.new_yblock, {5'd4,5'd3,5'd2,5'd1});

        // Cell 2 occupied
        board[5][3] = 1'b1;
        run_req(CYAN, 1, ROT_LEFT, {5'd3,5'd4,5'd5,5'd6}, {4{5'd2}},
                {4{5'd5}}, {5'd4,5'd3,5'd2,5'd1}, -1, -1, dc, nd, mk_, lx, ly);
        board[5][3] = 1'b0;
        chk("t2_done_cyc", dc, 8);
        chk("t2_rd_mask", mk_, 32'h54);
        chk("t2_last_rd", {lx[15:0], ly[15:0]}, {16'd5, 16'd3});
        chk("t2_acc", bus.accepted, 0);
        chk("t2_ori_held", bus.new_orientation, ROT_LEFT);

        // Wrapped x, then y at the board height
        run_req(GREEN, 1, NORMAL, '0, '0, {5'd31,5'd5,5'd5,5'd5}, {5'd4,5'd3,5'd2,5'd1},
                -1, -1, dc, nd, mk_, lx, ly);
        chk("t3a_done_cyc", dc, 2);
        chk("t3a_rd_mask", mk_, 0);
        chk("t3a_acc", bus.accepted, 0);
        run_req(RED, 0, ROT2, '0, '0, {4{5'd5}}, {5'd4,5'd3,5'd2,5'd20},
                -1, -1, dc, nd, mk_, lx, ly);
        chk("t3b_done_cyc", dc, 2);
        chk("t3b_rd_mask", mk_, 0);
        chk("t3b_ori_held", bus.new_orientation, ROT_LEFT);

        // YELLOW commits its current cells and orientation
        run_req(YELLOW, 1, ROT2, {5'd4,5'd5,5'd4,5'd5}, {5'd1,5'd1,5'd0,5'd0},
                {4{5'd31}}, {4{5'd31}}, -1, -1, dc, nd, mk_, lx, ly);
        chk("t4_done_cyc", dc, 1);
        chk("t4_rd_mask", mk_, 0);
        chk("t4_acc", bus.accepted, 1);
        chk("t4_new_x", bus.new_xblock, {5'd4,5'd5,5'd4,5'd5});
        chk("t4_new_y", bus.new_yblock, {5'd1,5'd1,5'd0,5'd0});
        chk("t4_ori", bus.new_orientation, ROT2);

        // Right rotation with a second pulse while busy
        run_req(PURPLE, 0, NORMAL, '0, '0, {5'd3,5'd4,5'd5,5'd6}, {4{5'd7}},
                3, -1, dc, nd, mk_, lx, ly);
        chk("t5_done_cyc", dc, 10);
        chk("t5_ndone", nd, 1);
        chk("t5_ori", bus.new_orientation, ROT_RIGHT);

        // Reset in cycle 5 aborts the request
        run_req(CYAN, 1, NORMAL, '0, '0, {4{5'd5}}, {5'd4,5'd3,5'd2,5'd1},
                -1, 5, dc, nd, mk_, lx, ly);
        chk("t6_ndone", nd, 0);
        chk("t6_busy", snap_busy, 0);
        chk("t6_rden", snap_rden, 0);
        chk("t6_ori", snap_ori, NORMAL);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            if (t % 25 == 0) begin
                for (int x = 0; x < BW; x++)
                    for (int y = 0; y < BH; y++)
                        board[x][y] = ($urandom % 10 == 0);
            end
            repeat ($urandom % 3) begin
                @(negedge clk);
                scramble();
                bus.rot_req = 1'b0;
            end
            @(negedge clk);
            scramble();
            bus.rot_xblock = rand_cells(BW);
            bus.rot_yblock = rand_cells(BH);
            bus.rot_req    = 1'b1;
            fin = 0;
            for (int c = 1; c <= 24 && !fin; c++) begin
                @(negedge clk);
                scramble();
                bus.rot_req = 1'b0;
                Reset       = 1'b0;
                if (!cur.busy) fin = 1;
                else begin
                    bus.rot_req = ($urandom % 5 == 0);
                    Reset       = ($urandom % 80 == 0);
                end
            end
            chk("rand_complete", fin, 1);
        end
        bus.rot_req = 1'b0;
        Reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/rotate_commit.md
# rotate_commit

Sequential rotation arbiter sitting between `rotate_blocks` and the board memory. On a rotation request it takes the proposed packed coordinates, checks all four cells against the board bounds and the locked-cell board through a one-cycle-latency read port, and then either commits the new coordinates and orientation or rejects the rotation. The game controller issues the request and consumes the result.

## Interface

Parameters:

- `BOARD_W`, default 10: board width in cells; legal x is 0..BOARD_W-1.
- `BOARD_H`, default 20: board height in cells; legal y is 0..BOARD_H-1.

Ports:

- `Clk` input, 1 bit: the single clock.
- `Reset` input, 1 bit: synchronous, active-high.
- `rot_req` input, 1 bit: rotation request; sampled only in IDLE.
- `rotate_left` input, 1 bit: 1 = left (CCW), 0 = right.
- `block` input, `block_color`: piece type.
- `cur_orientation` input, `orientation`: current orientation.
- `x_block`, `y_block` input, 20 bits each: current cells; cell i is at [5i+4:5i].
- `rot_xblock`, `rot_yblock` input, 20 bits each: proposed cells from `rotate_blocks`, same packing.
- `rd_en` output, 1 bit: board read strobe.
- `rd_x`, `rd_y` output, 5 bits each: board read address.
- `rd_data` input, 1 bit: 1 = cell locked; valid the cycle after `rd_en`.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle completion pulse.
- `accepted` output, 1 bit: result of the last request; valid with `done` and held until the next `done`.
- `new_xblock`, `new_yblock` output, 20 bits each: committed cells.
- `new_orientation` output, `orientation`: committed orientation.

## Operation

- All outputs are registered except `rd_en`, `rd_x` and `rd_y`, which are decoded from the state and the latched cell index.
- Reset values:
  - state IDLE, `busy` 0, `done` 0, `accepted` 0.
  - `rd_en` 0, `rd_x` 0, `rd_y` 0.
  - `new_xblock` 0, `new_yblock` 0, `new_orientation` NORMAL.
- In IDLE with `rot_req`=1, latch `block`, `rotate_left`, `cur_orientation`, `x_block`/`y_block` and `rot_xblock`/`rot_yblock`.
  - If the block is YELLOW, go to RESP with the accept flag set.
  - Otherwise clear the cell index and go to BOUNDS.
- Inputs are not used after the latch; changes while busy have no effect.
- BOUNDS: coordinates are unsigned 5-bit. A value wrapped by `rotate_blocks` (for example 0-1 = 31) therefore fails the bounds test.
  - If any cell has x ≥ BOARD_W or y ≥ BOARD_H, reject and go to RESP.
  - Otherwise go to READ.
- READ: drive `rd_en`=1 with `rd_x`/`rd_y` set to proposed cell[idx], then go to WAIT.
- WAIT: sample `rd_data`.
  - If 1, reject and go to RESP.
  - Else if idx = 3, accept and go to RESP.
  - Else increment idx and go to READ.
- Cells are read in order 0, 1, 2, 3, and reads stop at the first occupied cell.
- The board holds only locked cells; the active piece is never in it, so the piece's own current cells never cause a rejection.
- RESP: `done`=1 for exactly one cycle, `accepted` takes the result, then go to IDLE.
  - On accept, `new_xblock`/`new_yblock` take the latched proposed cells. For YELLOW they take the latched current cells.
  - On accept, `new_orientation` advances. Left: NORMAL→ROT_LEFT→ROT2→ROT_RIGHT→NORMAL. Right: the reverse. YELLOW keeps its orientation.
  - On reject, the `new_*` outputs hold their previous values.
- `rot_req` is ignored in every state other than IDLE; nothing is queued.
- A `rot_req` in the cycle after `done` is serviced normally.

## Timing

- Cycle numbering: `rot_req` is sampled at the edge ending cycle 0.
- Full accept: BOUNDS in cycle 1, READ/WAIT pairs in cycles 2–9, `done`=1 in cycle 10.
  - `rd_en` is high in cycles 2, 4, 6 and 8.
- Bounds reject: `done` in cycle 2, with no `rd_en`.
- Occupied cell k (k = 0..3): `done` in cycle 4+2k.
- YELLOW: `done` in cycle 1, with no `rd_en`.
- `busy` is high from cycle 1 through the `done` cycle inclusive, and low in the cycle after `done`.
- `Reset` in any cycle: the next cycle is in IDLE with all outputs at their reset values. No `done` is produced for the aborted request, and `rd_en` is 0 the next cycle.

## Test plan

- CYAN, NORMAL, left, proposed x = {5,5,5,5}, y = {4,3,2,1}, empty board.
  - Expect `rd_en` in cycles 2/4/6/8 with addresses (5,1), (5,2), (5,3), (5,4).
  - Expect `done` in cycle 10, `accepted`=1, `new_orientation`=ROT_LEFT, `new_*` equal to the proposed cells.
- Same request with board cell (5,3) locked.
  - Expect `done` in cycle 8, `accepted`=0, `new_*` unchanged, no read after cell 2.
- Proposed x cell 3 = 31 (wrapped), or y = 20 with BOARD_H = 20.
  - Expect `done` in cycle 2, `accepted`=0, `rd_en` never asserted.
- YELLOW request.
  - Expect `done` in cycle 1, `accepted`=1, `new_*` equal to `x_block`/`y_block`, orientation unchanged.
- Right rotation from NORMAL on an empty board.
  - Expect `new_orientation`=ROT_RIGHT.
  - A second `rot_req` pulse sent while busy produces no second `done`.
- `Reset` asserted in cycle 5 of a request.
  - Expect the next cycle to show `busy`=0, `rd_en`=0, `new_orientation`=NORMAL, and no `done` for that request.
